// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer for the NanoRisc core
//
// Owns the program counter, drives the instruction-memory address, captures
// the returned byte and presents it to decode over a valid/ready handshake.
// Handles branch redirects, HALT/program-end detection and a saturating
// retired-instruction count.
//
// Ports:
//   clock           system clock, all state changes on posedge
//   reset           synchronous active-low reset
//   inEnable        fetch permission (low pauses new fetches)
//   inData          instruction byte returned by memory one cycle after outAddress
//   outAddress      fetch address (always equal to the pc)
//   outInstruction  captured instruction presented to decode
//   outPc           address of outInstruction
//   outValid        outInstruction valid
//   inReady         decode accepts outInstruction this cycle
//   inBranch        redirect request
//   inBranchTarget  redirect address
//   outHalted       fetching stopped by HALT or program end
//   outRetired      saturating count of accepted instructions
module fetch_controller #(
    parameter int unsigned                ADDR_WIDTH  = 8,
    parameter int unsigned                DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]      START_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0]      LAST_ADDR   = 18,
    parameter logic [DATA_WIDTH-1:0]      HALT_OPCODE = 8'hFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inEnable,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic [ADDR_WIDTH-1:0] outAddress,
    output logic [DATA_WIDTH-1:0] outInstruction,
    output logic [ADDR_WIDTH-1:0] outPc,
    output logic                  outValid,
    input  logic                  inReady,
    input  logic                  inBranch,
    input  logic [ADDR_WIDTH-1:0] inBranchTarget,
    output logic                  outHalted,
    output logic [15:0]           outRetired
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic [1:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] pc_q,      pc_d;
    logic [DATA_WIDTH-1:0] instr_q,   instr_d;
    logic [ADDR_WIDTH-1:0] out_pc_q,  out_pc_d;
    logic [15:0]           retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        out_pc_d  = out_pc_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (inEnable) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A redirect wins over the byte arriving this cycle: that
                // byte belongs to the old pc and is dropped.
                if (inBranch) begin
                    pc_d = inBranchTarget;
                end else if (inEnable) begin
                    instr_d  = inData;
                    out_pc_d = pc_q;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (inReady) begin
                    if (retired_q != 16'hFFFF) begin
                        retired_d = retired_q + 16'd1;
                    end
                    // HALT takes priority over a same-cycle branch; program
                    // end only applies when the flow is sequential.
                    if (instr_q == HALT_OPCODE) begin
                        state_d = ST_HALTED;
                    end else if (inBranch) begin
                        pc_d    = inBranchTarget;
                        state_d = ST_FETCH;
                    end else if (out_pc_q == LAST_ADDR) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d    = out_pc_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_ADDR;
            instr_q   <= '0;
            out_pc_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            out_pc_q  <= out_pc_d;
            retired_q <= retired_d;
        end
    end

    assign outAddress     = pc_q;
    assign outInstruction = instr_q;
    assign outPc          = out_pc_q;
    assign outValid       = (state_q == ST_ISSUE);
    assign outHalted      = (state_q == ST_HALTED);
    assign outRetired     = retired_q;

endmodule
